// File: rtl/dport_source.sv
// rtl/dport_source.sv - host-fed byte FIFO presenting a read port with end-of-stream tracking
//
// Purpose:
//   Bytes pushed by the host side are queued in a circular buffer and presented
//   head-first on the system read port. A push flagged with host_last closes the
//   stream: later pushes are ignored, and once that final byte has been popped
//   dport_eof stays high until reset.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   host_data    byte offered by the host
//   host_push    push strobe for host_data
//   host_last    marks the pushed byte as the final byte of the stream
//   host_full    high when the FIFO holds DEPTH bytes
//   dport_in     head byte while dport_valid, else 8'h00
//   dport_read   pop strobe from the system side
//   dport_valid  high while the FIFO holds at least one byte
//   dport_eof    high once the final byte has been popped
//   count        bytes currently held
//   overflow     sticky: a push was dropped because the FIFO was full
//   underflow    sticky: a pop was attempted while the FIFO was empty

module dport_source #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             host_data,
    input  logic                   host_push,
    input  logic                   host_last,
    output logic                   host_full,
    output logic [7:0]             dport_in,
    input  logic                   dport_read,
    output logic                   dport_valid,
    output logic                   dport_eof,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_STREAM,
        S_LAST_PENDING,
        S_EOF
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] last_slot_q, last_slot_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_req;
    logic push_ok;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_COUNT);
    assign pop_ok = dport_read && !empty;

    // Once the stream is closed, pushes are silently discarded: they are
    // neither stored nor counted as overflow.
    assign push_req = host_push && (state_q == S_STREAM);

    // A full FIFO can still take a byte if the head leaves in the same cycle.
    assign push_ok = push_req && (!full || pop_ok);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_slot_d = last_slot_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_req && full && !pop_ok) begin
            overflow_d = 1'b1;
        end
        if (dport_read && empty) begin
            underflow_d = 1'b1;
        end

        case (state_q)
            S_STREAM: begin
                if (push_ok && host_last) begin
                    last_slot_d = wr_ptr_q;
                    state_d     = S_LAST_PENDING;
                end
            end
            S_LAST_PENDING: begin
                // No pushes are accepted here, so the recorded slot is the
                // youngest entry and is reached only when it is the last one.
                if (pop_ok && (rd_ptr_q == last_slot_q)) begin
                    state_d = S_EOF;
                end
            end
            S_EOF: begin
                state_d = S_EOF;
            end
            default: begin
                state_d = S_STREAM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_STREAM;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_slot_q <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_slot_q <= last_slot_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; emptiness is tracked by count_q,
    // which masks stale contents from dport_in.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_q[wr_ptr_q] <= host_data;
        end
    end

    assign dport_valid = !empty;
    assign dport_in    = dport_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign host_full   = full;
    assign dport_eof   = (state_q == S_EOF);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
